// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the 8-bit bus CPU control unit: opcodes, control
// word bit positions and the per-opcode instruction length.
package cpu_ctrl_pkg;

    localparam int MAX_STEPS = 5;
    localparam int STEP_W    = $clog2(MAX_STEPS);
    localparam int CTRL_W    = 16;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam int CTRL_PC_OUT   = 0;
    localparam int CTRL_PC_IN    = 1;
    localparam int CTRL_PC_INC   = 2;
    localparam int CTRL_MAR_IN   = 3;
    localparam int CTRL_RAM_OUT  = 4;
    localparam int CTRL_RAM_IN   = 5;
    localparam int CTRL_IR_OUT   = 6;
    localparam int CTRL_IR_IN    = 7;
    localparam int CTRL_A_OUT    = 8;
    localparam int CTRL_A_IN     = 9;
    localparam int CTRL_B_IN     = 10;
    localparam int CTRL_ALU_OUT  = 11;
    localparam int CTRL_ALU_SUB  = 12;
    localparam int CTRL_FLAGS_IN = 13;
    localparam int CTRL_OUT_IN   = 14;
    localparam int CTRL_HLT      = 15;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Index of the final T-state of an instruction. Jumps retire
    // after T2 whether or not they are taken.
    function automatic logic [STEP_W-1:0] last_step(
        input logic [3:0] op,
        input logic       fc,
        input logic       fz
    );
        logic [STEP_W-1:0] r;
        case (op)
            OP_LDA, OP_STA: r = STEP_W'(3);
            OP_ADD, OP_SUB: r = STEP_W'(4);
            OP_LDI, OP_JMP,
            OP_OUT, OP_HLT: r = STEP_W'(2);
            OP_JC:          r = fc ? STEP_W'(2) : STEP_W'(2);
            OP_JZ:          r = fz ? STEP_W'(2) : STEP_W'(2);
            default:        r = STEP_W'(1);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: run/opcode/flags in, control word,
// T-state and halt status out. master = sequencer, slave = datapath.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic              run;
    logic [3:0]        opcode;
    logic              flag_c;
    logic              flag_z;
    ctrl_t             ctrl;
    logic [STEP_W-1:0] step;
    logic              halted;

    modport master (
        input  run, opcode, flag_c, flag_z,
        output ctrl, step, halted
    );

    modport slave (
        output run, opcode, flag_c, flag_z,
        input  ctrl, step, halted
    );
endinterface

// File: rtl/control_sequencer_rom.sv
// Microcode ROM: purely combinational (opcode, step, flags) -> ctrl word.
// Ports: opcode[3:0], step, flag_c, flag_z in; ctrl out.
module control_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic [STEP_W-1:0] step,
    input  logic              flag_c,
    input  logic              flag_z,
    output ctrl_t             ctrl
);

    logic t2;
    logic t3;
    logic t4;

    assign t2 = (step == STEP_W'(2));
    assign t3 = (step == STEP_W'(3));
    assign t4 = (step == STEP_W'(4));

    always_comb begin
        ctrl = '0;
        if (step == STEP_W'(0)) begin
            ctrl[CTRL_PC_OUT] = 1'b1;
            ctrl[CTRL_MAR_IN] = 1'b1;
        end else if (step == STEP_W'(1)) begin
            ctrl[CTRL_RAM_OUT] = 1'b1;
            ctrl[CTRL_IR_IN]   = 1'b1;
            ctrl[CTRL_PC_INC]  = 1'b1;
        end else begin
            case (opcode)
                OP_LDA: begin
                    ctrl[CTRL_IR_OUT]  = t2;
                    ctrl[CTRL_MAR_IN]  = t2;
                    ctrl[CTRL_RAM_OUT] = t3;
                    ctrl[CTRL_A_IN]    = t3;
                end
                OP_ADD, OP_SUB: begin
                    ctrl[CTRL_IR_OUT]   = t2;
                    ctrl[CTRL_MAR_IN]   = t2;
                    ctrl[CTRL_RAM_OUT]  = t3;
                    ctrl[CTRL_B_IN]     = t3;
                    ctrl[CTRL_ALU_OUT]  = t4;
                    ctrl[CTRL_A_IN]     = t4;
                    ctrl[CTRL_FLAGS_IN] = t4;
                    ctrl[CTRL_ALU_SUB]  = t4 & (opcode == OP_SUB);
                end
                OP_STA: begin
                    ctrl[CTRL_IR_OUT] = t2;
                    ctrl[CTRL_MAR_IN] = t2;
                    ctrl[CTRL_A_OUT]  = t3;
                    ctrl[CTRL_RAM_IN] = t3;
                end
                OP_LDI: begin
                    ctrl[CTRL_IR_OUT] = t2;
                    ctrl[CTRL_A_IN]   = t2;
                end
                OP_JMP: begin
                    ctrl[CTRL_IR_OUT] = t2;
                    ctrl[CTRL_PC_IN]  = t2;
                end
                OP_JC: begin
                    ctrl[CTRL_IR_OUT] = t2 & flag_c;
                    ctrl[CTRL_PC_IN]  = t2 & flag_c;
                end
                OP_JZ: begin
                    ctrl[CTRL_IR_OUT] = t2 & flag_z;
                    ctrl[CTRL_PC_IN]  = t2 & flag_z;
                end
                OP_OUT: begin
                    ctrl[CTRL_A_OUT]  = t2;
                    ctrl[CTRL_OUT_IN] = t2;
                end
                OP_HLT: begin
                    ctrl[CTRL_HLT] = t2;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: T-state counter, sticky halt, run gating.
// Ports: clk, rst_n (async low); bus (master): run/opcode/flags in,
// ctrl/step/halted out.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MAX_STEPS       = cpu_ctrl_pkg::MAX_STEPS,
    parameter bit TERMINATE_EARLY = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    control_sequencer_if.master bus
);

    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              halted_q;
    logic              halted_d;
    logic [STEP_W-1:0] end_step;
    ctrl_t             rom_ctrl;
    ctrl_t             ctrl_w;

    control_rom u_rom (
        .opcode (bus.opcode),
        .step   (step_q),
        .flag_c (bus.flag_c),
        .flag_z (bus.flag_z),
        .ctrl   (rom_ctrl)
    );

    always_comb begin
        if (TERMINATE_EARLY) begin
            end_step = last_step(bus.opcode, bus.flag_c, bus.flag_z);
        end else begin
            end_step = STEP_W'(MAX_STEPS - 1);
        end
    end

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q && bus.run) begin
            if (bus.opcode == OP_HLT && step_q == STEP_W'(2)) begin
                halted_d = 1'b1;
                step_d   = '0;
            end else if (step_q == end_step) begin
                step_d = '0;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Reset gates ctrl directly so no strobe fires while rst_n is low.
    always_comb begin
        ctrl_w = '0;
        if (!rst_n) begin
            ctrl_w = '0;
        end else if (halted_q) begin
            ctrl_w[CTRL_HLT] = 1'b1;
        end else if (bus.run) begin
            ctrl_w = rom_ctrl;
        end
    end

    assign bus.ctrl   = ctrl_w;
    assign bus.step   = step_q;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: early-terminating and padded
// instances, pause/resume, halt and bus-writer exclusivity.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [15:0] BUS_WR = 16'h0951;

    always #5 clk = ~clk;

    control_sequencer_if if_e ();
    control_sequencer_if if_p ();

    control_sequencer #(.MAX_STEPS(5), .TERMINATE_EARLY(1'b1)) dut_e (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_e)
    );

    control_sequencer #(.MAX_STEPS(5), .TERMINATE_EARLY(1'b0)) dut_p (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_p)
    );

    always @(negedge clk) begin
        checks++;
        if ($countones(if_e.ctrl & BUS_WR) > 1) begin
            errors++;
            $display("FAIL bus_writers_e ctrl=%h", if_e.ctrl);
        end
        checks++;
        if ($countones(if_p.ctrl & BUS_WR) > 1) begin
            errors++;
            $display("FAIL bus_writers_p ctrl=%h", if_p.ctrl);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_e.ctrl !== 16'h0 || if_e.step !== 3'd0 || if_e.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_low ctrl=%h step=%0d halted=%b want 0000/0/0",
                     if_e.ctrl, if_e.step, if_e.halted);
        end
        tick(1);
        checks++;
        if (if_e.ctrl !== 16'h0 || if_e.step !== 3'd0 || if_p.ctrl !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold ctrl=%h step=%0d pctrl=%h want 0000/0/0000",
                     if_e.ctrl, if_e.step, if_p.ctrl);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (if_e.ctrl !== 16'h0009 || if_e.step !== 3'd0) begin
            errors++;
            $display("FAIL reset_release ctrl=%h step=%0d want 0009/0",
                     if_e.ctrl, if_e.step);
        end
    endtask

    task automatic test_lda();
        logic [2:0]  es [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        logic [15:0] ec [5] = '{16'h0009, 16'h0094, 16'h0048, 16'h0210, 16'h0009};
        if_e.opcode = 4'h1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (if_e.step !== es[i] || if_e.ctrl !== ec[i]) begin
                errors++;
                $display("FAIL lda_t%0d step=%0d ctrl=%h want %0d/%h",
                         i, if_e.step, if_e.ctrl, es[i], ec[i]);
            end
            tick(1);
        end
    endtask

    task automatic test_alu();
        if_e.opcode = 4'h3;
        do_reset();
        tick(4);
        checks++;
        if (if_e.step !== 3'd4 || if_e.ctrl !== 16'h3A00) begin
            errors++;
            $display("FAIL sub_t4 step=%0d ctrl=%h want 4/3a00", if_e.step, if_e.ctrl);
        end
        tick(1);
        checks++;
        if (if_e.step !== 3'd0) begin
            errors++;
            $display("FAIL sub_wrap step=%0d want 0", if_e.step);
        end
        if_e.opcode = 4'h2;
        tick(3);
        checks++;
        if (if_e.step !== 3'd3 || if_e.ctrl !== 16'h0410) begin
            errors++;
            $display("FAIL add_t3 step=%0d ctrl=%h want 3/0410", if_e.step, if_e.ctrl);
        end
        tick(1);
        checks++;
        if (if_e.step !== 3'd4 || if_e.ctrl !== 16'h2A00) begin
            errors++;
            $display("FAIL add_t4 step=%0d ctrl=%h want 4/2a00", if_e.step, if_e.ctrl);
        end
        tick(1);
        checks++;
        if (if_e.step !== 3'd0) begin
            errors++;
            $display("FAIL add_wrap step=%0d want 0", if_e.step);
        end
    endtask

    task automatic test_jumps();
        if_e.opcode = 4'h7;
        if_e.flag_c = 1'b0;
        do_reset();
        tick(2);
        checks++;
        if (if_e.step !== 3'd2 || if_e.ctrl !== 16'h0000) begin
            errors++;
            $display("FAIL jc_untaken step=%0d ctrl=%h want 2/0000", if_e.step, if_e.ctrl);
        end
        tick(1);
        checks++;
        if (if_e.step !== 3'd0) begin
            errors++;
            $display("FAIL jc_untaken_next step=%0d want 0", if_e.step);
        end
        if_e.flag_c = 1'b1;
        tick(2);
        checks++;
        if (if_e.ctrl !== 16'h0042) begin
            errors++;
            $display("FAIL jc_taken ctrl=%h want 0042", if_e.ctrl);
        end
        tick(1);
        if_e.opcode = 4'h8;
        if_e.flag_c = 1'b0;
        if_e.flag_z = 1'b1;
        tick(2);
        checks++;
        if (if_e.step !== 3'd2 || if_e.ctrl !== 16'h0042) begin
            errors++;
            $display("FAIL jz_taken step=%0d ctrl=%h want 2/0042", if_e.step, if_e.ctrl);
        end
        tick(1);
        if_e.flag_z = 1'b0;
        tick(2);
        checks++;
        if (if_e.ctrl !== 16'h0000) begin
            errors++;
            $display("FAIL jz_untaken ctrl=%h want 0000", if_e.ctrl);
        end
        tick(1);
        checks++;
        if (if_e.step !== 3'd0) begin
            errors++;
            $display("FAIL jz_next step=%0d want 0", if_e.step);
        end
    endtask

    task automatic test_misc_ops();
        logic [3:0]  op [4] = '{4'h4, 4'h5, 4'h6, 4'hE};
        logic [15:0] t2 [4] = '{16'h0048, 16'h0240, 16'h0042, 16'h4100};
        logic [2:0]  nx [4] = '{3'd3, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 4; i++) begin
            if_e.opcode = op[i];
            do_reset();
            tick(2);
            checks++;
            if (if_e.ctrl !== t2[i]) begin
                errors++;
                $display("FAIL op%h_t2 ctrl=%h want %h", op[i], if_e.ctrl, t2[i]);
            end
            tick(1);
            checks++;
            if (if_e.step !== nx[i]) begin
                errors++;
                $display("FAIL op%h_next step=%0d want %0d", op[i], if_e.step, nx[i]);
            end
        end
        checks++;
        if (if_e.ctrl !== 16'h0009) begin
            errors++;
            $display("FAIL out_refetch ctrl=%h want 0009", if_e.ctrl);
        end
        if_e.opcode = 4'h4;
        do_reset();
        tick(3);
        checks++;
        if (if_e.ctrl !== 16'h0120) begin
            errors++;
            $display("FAIL sta_t3 ctrl=%h want 0120", if_e.ctrl);
        end
        if_e.opcode = 4'h0;
        do_reset();
        tick(1);
        checks++;
        if (if_e.step !== 3'd1 || if_e.ctrl !== 16'h0094) begin
            errors++;
            $display("FAIL nop_t1 step=%0d ctrl=%h want 1/0094", if_e.step, if_e.ctrl);
        end
        tick(1);
        checks++;
        if (if_e.step !== 3'd0) begin
            errors++;
            $display("FAIL nop_next step=%0d want 0", if_e.step);
        end
    endtask

    task automatic test_pause();
        if_e.opcode = 4'h2;
        do_reset();
        tick(3);
        if_e.run = 1'b0;
        #1;
        checks++;
        if (if_e.step !== 3'd3 || if_e.ctrl !== 16'h0000) begin
            errors++;
            $display("FAIL pause_entry step=%0d ctrl=%h want 3/0000", if_e.step, if_e.ctrl);
        end
        tick(4);
        checks++;
        if (if_e.step !== 3'd3 || if_e.ctrl !== 16'h0000) begin
            errors++;
            $display("FAIL pause_hold step=%0d ctrl=%h want 3/0000", if_e.step, if_e.ctrl);
        end
        if_e.run = 1'b1;
        #1;
        checks++;
        if (if_e.step !== 3'd3 || if_e.ctrl !== 16'h0410) begin
            errors++;
            $display("FAIL resume_t3 step=%0d ctrl=%h want 3/0410", if_e.step, if_e.ctrl);
        end
        tick(1);
        checks++;
        if (if_e.step !== 3'd4 || if_e.ctrl !== 16'h2A00) begin
            errors++;
            $display("FAIL resume_t4 step=%0d ctrl=%h want 4/2a00", if_e.step, if_e.ctrl);
        end
    endtask

    task automatic test_halt();
        if_e.opcode = 4'hF;
        do_reset();
        tick(2);
        checks++;
        if (if_e.step !== 3'd2 || if_e.ctrl !== 16'h8000 || if_e.halted !== 1'b0) begin
            errors++;
            $display("FAIL hlt_t2 step=%0d ctrl=%h halted=%b want 2/8000/0",
                     if_e.step, if_e.ctrl, if_e.halted);
        end
        tick(1);
        checks++;
        if (if_e.step !== 3'd0 || if_e.ctrl !== 16'h8000 || if_e.halted !== 1'b1) begin
            errors++;
            $display("FAIL hlt_enter step=%0d ctrl=%h halted=%b want 0/8000/1",
                     if_e.step, if_e.ctrl, if_e.halted);
        end
        if_e.run = 1'b0;
        if_e.opcode = 4'h1;
        tick(2);
        checks++;
        if (if_e.step !== 3'd0 || if_e.ctrl !== 16'h8000 || if_e.halted !== 1'b1) begin
            errors++;
            $display("FAIL hlt_run0 step=%0d ctrl=%h halted=%b want 0/8000/1",
                     if_e.step, if_e.ctrl, if_e.halted);
        end
        if_e.run = 1'b1;
        tick(3);
        checks++;
        if (if_e.step !== 3'd0 || if_e.ctrl !== 16'h8000 || if_e.halted !== 1'b1) begin
            errors++;
            $display("FAIL hlt_sticky step=%0d ctrl=%h halted=%b want 0/8000/1",
                     if_e.step, if_e.ctrl, if_e.halted);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_e.step !== 3'd0 || if_e.ctrl !== 16'h0000 || if_e.halted !== 1'b0) begin
            errors++;
            $display("FAIL hlt_clear step=%0d ctrl=%h halted=%b want 0/0000/0",
                     if_e.step, if_e.ctrl, if_e.halted);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_padded();
        logic [15:0] ec [6] = '{16'h0009, 16'h0094, 16'h0, 16'h0, 16'h0, 16'h0009};
        logic [2:0]  es [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        if_p.opcode = 4'h9;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (if_p.step !== es[i] || if_p.ctrl !== ec[i]) begin
                errors++;
                $display("FAIL pad_t%0d step=%0d ctrl=%h want %0d/%h",
                         i, if_p.step, if_p.ctrl, es[i], ec[i]);
            end
            tick(1);
        end
        if_p.opcode = 4'h1;
        do_reset();
        tick(3);
        checks++;
        if (if_p.ctrl !== 16'h0210) begin
            errors++;
            $display("FAIL pad_lda_t3 ctrl=%h want 0210", if_p.ctrl);
        end
        tick(1);
        checks++;
        if (if_p.step !== 3'd4 || if_p.ctrl !== 16'h0000) begin
            errors++;
            $display("FAIL pad_lda_t4 step=%0d ctrl=%h want 4/0000", if_p.step, if_p.ctrl);
        end
    endtask

    initial begin
        if_e.run = 1'b1;
        if_e.opcode = 4'h1;
        if_e.flag_c = 1'b0;
        if_e.flag_z = 1'b0;
        if_p.run = 1'b1;
        if_p.opcode = 4'h9;
        if_p.flag_c = 1'b0;
        if_p.flag_z = 1'b0;
        test_reset();
        test_lda();
        test_alu();
        test_jumps();
        test_misc_ops();
        test_pause();
        test_halt();
        test_padded();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
